// File: rtl/muldiv_unit.sv
// Iterative 32-bit unsigned multiply/divide unit: shift-add MUL/MULHU, restoring DIVU/REMU.
// The divider datapath is present only when MULDIV_DIVIDE_EN is defined.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  MulDiv_Control,
    input  logic [31:0] input_A,
    input  logic [31:0] input_B,
    output logic        ready,
    output logic        done,
    output logic [31:0] result,
    output logic        Zero_Flag
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ACC_W = 2 * XLEN;
    localparam int unsigned CNT_W = 5;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   fin;
`ifdef MULDIV_DIVIDE_EN
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     rem_diff;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            b_q      <= '0;
            acc_q    <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
`ifdef MULDIV_DIVIDE_EN
            rem_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifdef MULDIV_DIVIDE_EN
            rem_q    <= rem_d;
`endif
        end
    end

    // Next-state, datapath step and registered-output computation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        b_d      = b_q;
        acc_d    = acc_q;
        done_d   = 1'b0;
        result_d = result_q;
        zero_d   = zero_q;
        mul_sum  = {1'b0, acc_q[ACC_W-1:XLEN]} + {1'b0, b_q};
        fin      = '0;
`ifdef MULDIV_DIVIDE_EN
        rem_d    = rem_q;
        rem_sh   = {rem_q, acc_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, b_q};
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d  = MulDiv_Control;
                    b_d   = input_B;
                    cnt_d = '0;
                    acc_d = {{XLEN{1'b0}}, input_A};
`ifdef MULDIV_DIVIDE_EN
                    rem_d   = '0;
                    state_d = ST_CALC;
`else
                    // Divide ops complete immediately with a zero result
                    if (MulDiv_Control[1]) begin
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        result_d = '0;
                        zero_d   = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                    end
`endif
                end
            end

            ST_CALC: begin
`ifdef MULDIV_DIVIDE_EN
                if (op_q[1]) begin
                    // Restoring step: quotient bits shift in where dividend bits leave
                    if (!rem_diff[XLEN]) begin
                        rem_d = rem_diff[XLEN-1:0];
                        acc_d = {acc_q[ACC_W-1:XLEN], acc_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[XLEN-1:0];
                        acc_d = {acc_q[ACC_W-1:XLEN], acc_q[XLEN-2:0], 1'b0};
                    end
                end else
`endif
                if (acc_q[0]) begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end else begin
                    acc_d = {1'b0, acc_q[ACC_W-1:1]};
                end

                case (op_q)
                    OP_MUL:   fin = acc_d[XLEN-1:0];
                    OP_MULHU: fin = acc_d[ACC_W-1:XLEN];
`ifdef MULDIV_DIVIDE_EN
                    OP_DIVU:  fin = acc_d[XLEN-1:0];
                    OP_REMU:  fin = rem_d;
`else
                    OP_DIVU:  fin = '0;
                    OP_REMU:  fin = '0;
`endif
                    default:  fin = '0;
                endcase

                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    result_d = fin;
                    zero_d   = (fin == '0);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign result    = result_q;
    assign Zero_Flag = zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit; expectations for divide ops follow MULDIV_DIVIDE_EN.
module tb_muldiv_unit;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;
    localparam int MAX_WAIT = 60;
    localparam int NV = 15;
`ifdef MULDIV_DIVIDE_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  ctl = 2'b00;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic        zero;

    int checks = 0;
    int errors = 0;
    vec_t vec [NV];

    muldiv_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .MulDiv_Control (ctl),
        .input_A        (in_a),
        .input_B        (in_b),
        .ready          (ready),
        .done           (done),
        .result         (result),
        .Zero_Flag      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Divide-op expectations depend on whether the divider is built in
    function automatic logic [31:0] dexp(input logic [31:0] v);
        return DIV_EN ? v : 32'h0;
    endfunction

    function automatic int dlat();
        return DIV_EN ? 33 : 1;
    endfunction

    // Waits (bounded) for done; w = extra edges waited, saw_rdy = ready seen high meanwhile
    task automatic wait_done(output int w, output bit saw_rdy);
        w = 0;
        saw_rdy = 1'b0;
        while (!done && w < MAX_WAIT) begin
            if (ready) saw_rdy = 1'b1;
            @(posedge clk); #1;
            w++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=0 expected done=1 within %0d cycles", MAX_WAIT);
        end
    endtask

    task automatic post_done(input string name, input logic [31:0] exp);
        check({name, "_result"}, result, exp);
        check({name, "_zero"}, 32'(zero), 32'(exp == 32'h0));
        check({name, "_ready_at_done"}, 32'(ready), 32'd0);
        @(posedge clk); #1;
        check({name, "_done_pulse"}, 32'(done), 32'd0);
        check({name, "_ready_after"}, 32'(ready), 32'd1);
        check({name, "_result_hold"}, result, exp);
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int  w;
        bit  saw_rdy;
        @(negedge clk);
        check({name, "_ready_idle"}, 32'(ready), 32'd1);
        start = 1'b1; ctl = op; in_a = a; in_b = b;
        @(posedge clk); #1;
        // Scramble inputs after the accepting edge to prove operands were latched
        start = 1'b0; ctl = ~op; in_a = ~a; in_b = ~b;
        wait_done(w, saw_rdy);
        check({name, "_latency"}, 32'(1 + w), 32'(lat));
        check({name, "_ready_in_calc"}, 32'(saw_rdy), 32'd0);
        post_done(name, exp);
    endtask

    initial begin
        int  w;
        bit  saw_rdy;

        vec[0]  = '{OP_MUL,   32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 33};
        vec[1]  = '{OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vec[2]  = '{OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33};
        vec[3]  = '{OP_MUL,   32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 33};
        vec[4]  = '{OP_MULHU, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 33};
        vec[5]  = '{OP_MUL,   32'h8000_0000, 32'h0000_0004, 32'h0000_0000, 33};
        vec[6]  = '{OP_MULHU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 33};
        vec[7]  = '{OP_MUL,   32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33};
        vec[8]  = '{OP_DIVU,  32'd100,       32'd7,         dexp(32'd14),  dlat()};
        vec[9]  = '{OP_REMU,  32'd100,       32'd7,         dexp(32'd2),   dlat()};
        vec[10] = '{OP_DIVU,  32'd5,         32'd0,         dexp(32'hFFFF_FFFF), dlat()};
        vec[11] = '{OP_REMU,  32'd5,         32'd0,         dexp(32'd5),   dlat()};
        vec[12] = '{OP_DIVU,  32'd7,         32'd100,       dexp(32'd0),   dlat()};
        vec[13] = '{OP_REMU,  32'hFFFF_FFFF, 32'h0001_0000, dexp(32'h0000_FFFF), dlat()};
        vec[14] = '{OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_zero", 32'(zero), 32'd1);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_op($sformatf("vec%0d", i), vec[i].op, vec[i].a, vec[i].b, vec[i].exp, vec[i].lat);
        end

        // Start pulsed with new operands mid-CALC must be ignored
        @(negedge clk);
        start = 1'b1; ctl = OP_MUL; in_a = 32'd7; in_b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        ctl = OP_MULHU; in_a = 32'd3; in_b = 32'd3; start = 1'b1;
        check("ign_ready_calc", 32'(ready), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(w, saw_rdy);
        check("ign_latency", 32'(7 + w), 32'd33);
        check("ign_ready_in_calc", 32'(saw_rdy), 32'd0);
        post_done("ign", 32'h0000_002A);

        // Reset dropped at CALC cycle 10: outputs clear without a clock edge
        @(negedge clk);
        start = 1'b1; ctl = OP_MULHU; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        check("midrst_busy", 32'(ready), 32'd0);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", result, 32'h0);
        check("midrst_zero", 32'(zero), 32'd1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        run_op("after_rst", OP_MUL, 32'd3, 32'd3, 32'd9, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the bench never hangs
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port start  input  1  request; sampled only when ready=1.
REQ-004 SHALL have port MulDiv_Control  input  2  operation: 00 MUL (low 32 bits of the product), 01 MULHU (high 32 bits, unsigned), 10 DIVU, 11 REMU.
REQ-005 SHALL have port input_A  input  32  multiplicand or dividend, unsigned.
REQ-006 SHALL have port input_B  input  32  multiplier or divisor, unsigned.
REQ-007 SHALL have port ready  output  1  high in IDLE only.
REQ-008 SHALL have port done  output  1  one-cycle pulse when result is valid.
REQ-009 SHALL have port result  output  32  operation result, held until the next accepted start.
REQ-010 SHALL have port Zero_Flag  output  1  (result == 0), registered together with result.

Function
REQ-011 SHALL implement states IDLE, CALC and DONE.
REQ-012 SHALL accept start in IDLE, latch MulDiv_Control, input_A and input_B, clear the 5-bit iteration counter, and enter CALC on the next edge.
REQ-013 SHALL ignore start while in CALC or DONE; the latched operands SHALL NOT change.
REQ-014 SHALL perform one iteration per clock in CALC, 32 iterations in total, then enter DONE.
REQ-015 SHALL implement MUL and MULHU as 32-step shift-add into a 64-bit accumulator; MUL returns bits [31:0] and MULHU returns bits [63:32].
REQ-016 SHALL implement DIVU and REMU as 32-step restoring division with a 33-bit partial remainder; DIVU returns the quotient and REMU returns the remainder.
REQ-017 SHALL produce, for divisor 0, quotient 32'hFFFFFFFF and remainder input_A, with no special-case timing.
REQ-018 SHALL assert done, and update result and Zero_Flag, in DONE, which is cycle 33 after the accepting edge; the next edge SHALL return the unit to IDLE.
REQ-019 SHALL allow a new start to be accepted in the cycle after done, giving back-to-back throughput of one operation per 34 cycles.
REQ-020 SHALL hold result and Zero_Flag stable from DONE until the next DONE.
REQ-021 SHALL keep all arithmetic unsigned modulo 2^32 on result; overflow SHALL NOT be flagged.

Reset
REQ-022 SHALL, on reset_n=0 at any time (including mid-CALC), immediately force the state to IDLE, ready=1, done=0, result=0, Zero_Flag=1, counter=0 and accumulators=0.
REQ-023 SHALL accept start on the first clock edge after reset_n deasserts, with no lost or partial operation.

Configuration
REQ-024 SHALL compile in the divider datapath only when macro MULDIV_DIVIDE_EN is defined.
REQ-025 SHALL, with MULDIV_DIVIDE_EN undefined, accept ops 10 and 11, skip CALC, enter DONE on the next edge with result=0 and Zero_Flag=1, and contain no divider logic; ops 00 and 01 are unaffected.

Verification
REQ-026 SHALL cover: MUL, A=32'h0000_0007, B=32'h0000_0006 -> done exactly 33 cycles after accept, result=32'h0000_002A, Zero_Flag=0.
REQ-027 SHALL cover: MULHU, A=B=32'hFFFF_FFFF -> result=32'hFFFF_FFFE; repeat with MUL -> result=32'h0000_0001.
REQ-028 SHALL cover: DIVU, A=100, B=7 -> result=14; REMU with the same operands -> result=2; DIVU, A=5, B=0 -> result=32'hFFFF_FFFF; REMU, A=5, B=0 -> result=5.
REQ-029 SHALL cover: start pulsed with new operands during CALC -> ignored; the original result is returned; ready stays 0 until after done.
REQ-030 SHALL cover: reset_n dropped at CALC cycle 10 -> outputs reach reset values without a clock edge; a following MUL 3x3 -> result=9 after 33 cycles.
REQ-031 SHALL cover: build without MULDIV_DIVIDE_EN, DIVU 100/7 -> done after 1 cycle, result=0, Zero_Flag=1.
